cayde_decode: RTL and testbench

CAYDE_DECODE -- requirements
Module: cayde_decode

---
 rtl/cayde_decode_if.sv | 71 +++++++
 rtl/cayde_decode.sv | 222 ++++++++++++++++++++++
 tb/tb_cayde_decode.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cayde_decode_if.sv
// cayde_pkg / cayde_decode_if
//
// Purpose: shared ALU operation encoding, plus the handshake bundle that
// connects an instruction source, the cayde_decode stage and the execute
// stage.
//
// Signals carried by cayde_decode_if:
//   in_valid_i / in_ready_o          instruction-side handshake
//   insn_i, pc_i                     RV32I instruction word and its PC
//   rs1_data_i, rs2_data_i           register-file read data for insn_i
//   flush_i                          discard held and incoming instruction
//   out_valid_o / out_ready_i        execute-side handshake
//   alu_op_o, op_a_o, op_b_o         ALU request
//   rd_o, rd_we_o                    destination register and write enable
//   illegal_o                        held instruction is illegal
//
// Modports:
//   slave  - the decode stage (drives the *_o signals)
//   master - the environment (drives the *_i signals)

package cayde_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op;

endpackage

interface cayde_decode_if;
  import cayde_pkg::*;

  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] insn_i;
  logic [31:0] pc_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  alu_op       alu_op_o;
  logic [31:0] op_a_o;
  logic [31:0] op_b_o;
  logic [4:0]  rd_o;
  logic        rd_we_o;
  logic        illegal_o;

  modport slave (
    input  in_valid_i, insn_i, pc_i, rs1_data_i, rs2_data_i, flush_i,
           out_ready_i,
    output in_ready_o, out_valid_o, alu_op_o, op_a_o, op_b_o, rd_o,
           rd_we_o, illegal_o
  );

  modport master (
    output in_valid_i, insn_i, pc_i, rs1_data_i, rs2_data_i, flush_i,
           out_ready_i,
    input  in_ready_o, out_valid_o, alu_op_o, op_a_o, op_b_o, rd_o,
           rd_we_o, illegal_o
  );

endinterface

// File: rtl/cayde_decode.sv
// cayde_decode
//
// Purpose: RV32I decode stage. Turns an instruction word plus its PC and
// register-file read data into an ALU request, held in a single-entry
// pipeline register (EMPTY/FULL) with valid/ready handshakes on both sides.
// An accepted instruction appears on the outputs one cycle later.
//
// Ports:
//   clk_i  - core clock, all state updates on the rising edge
//   rst_i  - synchronous active-high reset
//   bus    - cayde_decode_if.slave; instruction input, flush, handshakes
//            and the registered ALU request
//
// Build option:
//   CAYDE_ILLEGAL_INSN_EN - when defined, unknown opcodes and malformed
//   funct7 fields are flagged on illegal_o with a neutral request
//   (ADD 0,0, no write-back). When undefined, illegal_o is tied low,
//   unknown opcodes become ADD rs1,0 without write-back, and OP/OP-IMM
//   decode from funct3 and bit 30 only.

module cayde_decode
  import cayde_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  cayde_decode_if.slave  bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] F7_STD = 7'b0000000;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  // ------------------------------------------------------------------
  // Instruction fields
  // ------------------------------------------------------------------
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [4:0]  w_rd;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_u;
  logic        w_is_shift_imm;

  assign w_opcode = bus.insn_i[6:0];
  assign w_funct3 = bus.insn_i[14:12];
  assign w_funct7 = bus.insn_i[31:25];
  assign w_rd     = bus.insn_i[11:7];
  assign w_imm_i  = {{20{bus.insn_i[31]}}, bus.insn_i[31:20]};
  assign w_imm_s  = {{20{bus.insn_i[31]}}, bus.insn_i[31:25], bus.insn_i[11:7]};
  assign w_imm_u  = {bus.insn_i[31:12], 12'b0};
  assign w_is_shift_imm = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

  // funct3 -> ALU op. 'alt' is instruction bit 30; it only selects SUB on
  // register-register ops, never on ADDI.
  function automatic alu_op f3_to_op(input logic [2:0] f3,
                                     input logic       alt,
                                     input logic       is_imm);
    alu_op op;
    unique case (f3)
      3'b000:  op = (alt && !is_imm) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

`ifdef CAYDE_ILLEGAL_INSN_EN
  // Legality check, only meaningful when illegal instructions are reported.
  logic w_known_opc;
  logic w_op_bad;
  logic w_opimm_bad;
  logic w_bad;

  assign w_known_opc = (w_opcode == OPC_OP)    || (w_opcode == OPC_OP_IMM) ||
                       (w_opcode == OPC_LUI)   || (w_opcode == OPC_AUIPC)  ||
                       (w_opcode == OPC_LOAD)  || (w_opcode == OPC_STORE);
  // funct7 0100000 is only meaningful for SUB (000) and SRA (101).
  assign w_op_bad    = (w_opcode == OPC_OP) &&
                       (((w_funct7 != F7_STD) && (w_funct7 != F7_ALT)) ||
                        ((w_funct7 == F7_ALT) && (w_funct3 != 3'b000) &&
                         (w_funct3 != 3'b101)));
  assign w_opimm_bad = (w_opcode == OPC_OP_IMM) && w_is_shift_imm &&
                       (w_funct7 != F7_STD) && (w_funct7 != F7_ALT);
  assign w_bad       = !w_known_opc || w_op_bad || w_opimm_bad;
`endif

  // ------------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // ------------------------------------------------------------------
  alu_op       w_alu_op;
  logic [31:0] w_op_a;
  logic [31:0] w_op_b;
  logic        w_rd_we;
  logic        w_illegal;

  always_comb begin
    // Defaults double as the unknown-opcode decode: ADD rs1,0, no write.
    w_alu_op  = ALU_ADD;
    w_op_a    = bus.rs1_data_i;
    w_op_b    = 32'd0;
    w_rd_we   = 1'b0;
    w_illegal = 1'b0;

    unique case (w_opcode)
      OPC_OP: begin
        w_op_b   = bus.rs2_data_i;
        w_alu_op = f3_to_op(w_funct3, bus.insn_i[30], 1'b0);
        w_rd_we  = (w_rd != 5'd0);
      end
      OPC_OP_IMM: begin
        w_op_b   = w_is_shift_imm ? {27'b0, bus.insn_i[24:20]} : w_imm_i;
        w_alu_op = f3_to_op(w_funct3, bus.insn_i[30], 1'b1);
        w_rd_we  = (w_rd != 5'd0);
      end
      OPC_LUI: begin
        w_op_a   = 32'd0;
        w_op_b   = w_imm_u;
        w_rd_we  = (w_rd != 5'd0);
      end
      OPC_AUIPC: begin
        w_op_a   = bus.pc_i;
        w_op_b   = w_imm_u;
        w_rd_we  = (w_rd != 5'd0);
      end
      OPC_LOAD: begin
        w_op_b   = w_imm_i;
        w_rd_we  = (w_rd != 5'd0);
      end
      OPC_STORE: begin
        w_op_b   = w_imm_s;
      end
      default: begin
      end
    endcase

`ifdef CAYDE_ILLEGAL_INSN_EN
    // Illegal instructions carry a neutral request so a downstream stage
    // that ignores illegal_o cannot corrupt architectural state.
    if (w_bad) begin
      w_alu_op  = ALU_ADD;
      w_op_a    = 32'd0;
      w_op_b    = 32'd0;
      w_rd_we   = 1'b0;
      w_illegal = 1'b1;
    end
`endif
  end

  // ------------------------------------------------------------------
  // Handshake
  // ------------------------------------------------------------------
  state_t      r_state;
  alu_op       r_alu_op;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic [4:0]  r_rd;
  logic        r_rd_we;
  logic        r_illegal;
  logic        w_in_ready;
  logic        w_accept;

  // Ready is forced high during reset so the source never stalls on a
  // slot that the reset is about to empty anyway.
  assign w_in_ready = rst_i || (r_state == S_EMPTY) || bus.out_ready_i;
  assign w_accept   = bus.in_valid_i && w_in_ready && !bus.flush_i;

  // ------------------------------------------------------------------
  // Pipeline register / FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_EMPTY;
      r_alu_op  <= ALU_ADD;
      r_op_a    <= 32'd0;
      r_op_b    <= 32'd0;
      r_rd      <= 5'd0;
      r_rd_we   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (bus.flush_i) begin
      // Flush drops the entry but leaves the payload registers as they
      // were; only the valid state matters downstream.
      r_state <= S_EMPTY;
    end else if (w_accept) begin
      r_state   <= S_FULL;
      r_alu_op  <= w_alu_op;
      r_op_a    <= w_op_a;
      r_op_b    <= w_op_b;
      r_rd      <= w_rd;
      r_rd_we   <= w_rd_we;
      r_illegal <= w_illegal;
    end else if (bus.out_ready_i) begin
      r_state <= S_EMPTY;
    end
  end

  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = (r_state == S_FULL);
  assign bus.alu_op_o    = r_alu_op;
  assign bus.op_a_o      = r_op_a;
  assign bus.op_b_o      = r_op_b;
  assign bus.rd_o        = r_rd;
  assign bus.rd_we_o     = r_rd_we;
  assign bus.illegal_o   = r_illegal;

endmodule

// File: tb/tb_cayde_decode.sv
// tb_cayde_decode
//
// Directed vectors with hand-computed expected ALU requests. The stimulus
// pushes the expected request into a scoreboard queue on the cycle the DUT
// accepts the instruction; a separate monitor pops and compares whenever
// the DUT hands a request to execute (out_valid_o & out_ready_i), and
// checks that outputs stay stable while stalled.

module tb_cayde_decode;
  import cayde_pkg::*;

  typedef struct {
    alu_op       op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   n_pushed;
  int   n_popped;
  exp_t sb[$];

  cayde_decode_if bus();

  cayde_decode dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(alu_op op, logic [31:0] a, logic [31:0] b,
                              logic [4:0] rd, logic we, logic ill);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.rd = rd; e.we = we; e.ill = ill;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Present one instruction and hold it until accepted; returns at
  // posedge+1 so consecutive calls stream one instruction per cycle.
  task automatic send(input string name, input logic [31:0] insn,
                      input logic [31:0] pc, input logic [31:0] r1,
                      input logic [31:0] r2, input exp_t e, input bit push);
    bus.in_valid_i = 1'b1;
    bus.insn_i     = insn;
    bus.pc_i       = pc;
    bus.rs1_data_i = r1;
    bus.rs2_data_i = r2;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.in_ready_o) begin
        if (push) begin
          sb.push_back(e);
          n_pushed++;
        end
        $display("send %s insn=%h pc=%h rs1=%h rs2=%h", name, insn, pc, r1, r2);
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout %s: in_ready_o stayed 0, want 1", name);
    bus.in_valid_i = 1'b0;
  endtask

  // ------------------------------------------------------------------
  // Monitor / scoreboard
  // ------------------------------------------------------------------
  logic  p_hold, p_flush, p_rst;
  alu_op p_op;
  logic [31:0] p_a, p_b;
  logic [4:0]  p_rd;
  logic  p_we, p_ill;

  initial begin
    p_hold = 1'b0; p_flush = 1'b0; p_rst = 1'b1;
    p_op = ALU_ADD; p_a = '0; p_b = '0; p_rd = '0; p_we = 1'b0; p_ill = 1'b0;
    forever begin
      @(negedge clk);
      if (p_hold && !p_flush && !p_rst) begin
        checks++;
        if (!bus.out_valid_o || bus.alu_op_o !== p_op || bus.op_a_o !== p_a ||
            bus.op_b_o !== p_b || bus.rd_o !== p_rd || bus.rd_we_o !== p_we ||
            bus.illegal_o !== p_ill) begin
          errors++;
          $display("FAIL hold: got v=%b op=%0d a=%h b=%h rd=%0d, want v=1 op=%0d a=%h b=%h rd=%0d",
                   bus.out_valid_o, bus.alu_op_o, bus.op_a_o, bus.op_b_o, bus.rd_o,
                   p_op, p_a, p_b, p_rd);
        end
      end
      if (bus.out_valid_o && bus.out_ready_i) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got op=%0d a=%h b=%h rd=%0d, want no output",
                   bus.alu_op_o, bus.op_a_o, bus.op_b_o, bus.rd_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          n_popped++;
          if (bus.alu_op_o !== e.op || bus.op_a_o !== e.a || bus.op_b_o !== e.b ||
              bus.rd_o !== e.rd || bus.rd_we_o !== e.we || bus.illegal_o !== e.ill) begin
            errors++;
            $display("FAIL out#%0d: got op=%0d a=%h b=%h rd=%0d we=%b ill=%b, want op=%0d a=%h b=%h rd=%0d we=%b ill=%b",
                     n_popped, bus.alu_op_o, bus.op_a_o, bus.op_b_o, bus.rd_o,
                     bus.rd_we_o, bus.illegal_o, e.op, e.a, e.b, e.rd, e.we, e.ill);
          end else begin
            $display("out#%0d op=%0d a=%h b=%h rd=%0d we=%b ill=%b", n_popped,
                     bus.alu_op_o, bus.op_a_o, bus.op_b_o, bus.rd_o,
                     bus.rd_we_o, bus.illegal_o);
          end
        end
      end
      p_hold  = bus.out_valid_o && !bus.out_ready_i;
      p_flush = bus.flush_i;
      p_rst   = rst;
      p_op = bus.alu_op_o; p_a = bus.op_a_o; p_b = bus.op_b_o;
      p_rd = bus.rd_o; p_we = bus.rd_we_o; p_ill = bus.illegal_o;
    end
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  initial begin
    exp_t e_ill;
    errors = 0; checks = 0; n_pushed = 0; n_popped = 0;
    rst = 1'b1;
    bus.in_valid_i = 1'b0; bus.insn_i = '0; bus.pc_i = '0;
    bus.rs1_data_i = '0; bus.rs2_data_i = '0;
    bus.flush_i = 1'b0; bus.out_ready_i = 1'b0;

`ifdef CAYDE_ILLEGAL_INSN_EN
    e_ill = mk(ALU_ADD, 32'h0, 32'h0, 5'd31, 1'b0, 1'b1);
`else
    e_ill = mk(ALU_ADD, 32'h77, 32'h0, 5'd31, 1'b0, 1'b0);
`endif

    // Reset and reset state
    @(negedge clk);
    chk("in_ready_during_rst", {31'b0, bus.in_ready_o}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'b0, bus.out_valid_o}, 32'd0);
    chk("rst_alu_op", {28'b0, bus.alu_op_o}, {28'b0, ALU_ADD});
    chk("rst_op_a", bus.op_a_o, 32'd0);
    chk("rst_op_b", bus.op_b_o, 32'd0);
    chk("rst_rd", {27'b0, bus.rd_o}, 32'd0);
    chk("rst_rd_we_ill", {30'b0, bus.rd_we_o, bus.illegal_o}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready_o}, 32'd1);
    @(posedge clk); #1;

    // Back-to-back stream with execute always ready
    bus.out_ready_i = 1'b1;
    send("addi", 32'hFFF08293, 32'h0, 32'd10, 32'h0,
         mk(ALU_ADD, 32'd10, 32'hFFFFFFFF, 5'd5, 1'b1, 1'b0), 1'b1);
    send("srai", 32'h4041D193, 32'h0, 32'h80000000, 32'h0,
         mk(ALU_SRA, 32'h80000000, 32'd4, 5'd3, 1'b1, 1'b0), 1'b1);
    send("sub", 32'h403100B3, 32'h0, 32'h50, 32'h20,
         mk(ALU_SUB, 32'h50, 32'h20, 5'd1, 1'b1, 1'b0), 1'b1);
    send("auipc", 32'h12345397, 32'h100, 32'h0, 32'h0,
         mk(ALU_ADD, 32'h100, 32'h12345000, 5'd7, 1'b1, 1'b0), 1'b1);
    send("lui", 32'hABCDE537, 32'h0, 32'h55, 32'h0,
         mk(ALU_ADD, 32'h0, 32'hABCDE000, 5'd10, 1'b1, 1'b0), 1'b1);
    repeat (2) @(posedge clk); #1;

    // Backpressure: store held for three cycles, load waits behind it
    bus.out_ready_i = 1'b0;
    send("sw", 32'hFE20AE23, 32'h0, 32'h1000, 32'h9,
         mk(ALU_ADD, 32'h1000, 32'hFFFFFFFC, 5'd28, 1'b0, 1'b0), 1'b1);
    bus.in_valid_i = 1'b1; bus.insn_i = 32'h00812203;
    bus.rs1_data_i = 32'h2000; bus.rs2_data_i = 32'h0; bus.pc_i = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'b0, bus.in_ready_o}, 32'd0);
      chk("bp_out_valid", {31'b0, bus.out_valid_o}, 32'd1);
      @(posedge clk); #1;
    end
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", {31'b0, bus.in_ready_o}, 32'd1);
    sb.push_back(mk(ALU_ADD, 32'h2000, 32'd8, 5'd4, 1'b1, 1'b0));
    n_pushed++;
    $display("send lw insn=00812203 accepted on release");
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Flush while FULL and stalled: held and incoming both dropped
    bus.out_ready_i = 1'b0;
    send("junk_held", 32'h00000013, 32'h0, 32'hDEAD0000, 32'h0,
         mk(ALU_ADD, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0), 1'b0);
    bus.in_valid_i = 1'b1; bus.insn_i = 32'h00108093;
    bus.rs1_data_i = 32'hBAD; bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0;
    @(negedge clk);
    chk("flush_full_valid", {31'b0, bus.out_valid_o}, 32'd0);
    chk("flush_keeps_data", bus.op_a_o, 32'hDEAD0000);

    // Flush while EMPTY and ready: overrides the accept
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b1; bus.insn_i = 32'h00108093; bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0;
    @(negedge clk);
    chk("flush_empty_valid", {31'b0, bus.out_valid_o}, 32'd0);
    @(posedge clk); #1;

    // More decode patterns
    send("add_x0", 32'h00208033, 32'h0, 32'd5, 32'd6,
         mk(ALU_ADD, 32'd5, 32'd6, 5'd0, 1'b0, 1'b0), 1'b1);
    send("sltu", 32'h0083B333, 32'h0, 32'd1, 32'd2,
         mk(ALU_SLTU, 32'd1, 32'd2, 5'd6, 1'b1, 1'b0), 1'b1);
    send("xori", 32'h7FF0C493, 32'h0, 32'h1234, 32'h0,
         mk(ALU_XOR, 32'h1234, 32'h7FF, 5'd9, 1'b1, 1'b0), 1'b1);
    send("illegal", 32'hFFFFFFFF, 32'h0, 32'h77, 32'h0, e_ill, 1'b1);
    repeat (2) @(posedge clk); #1;

    // Reset while FULL and stalled discards the entry
    bus.out_ready_i = 1'b0;
    send("junk_rst", 32'h00108093, 32'h0, 32'h4444, 32'h0,
         mk(ALU_ADD, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", {31'b0, bus.in_ready_o}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", {31'b0, bus.out_valid_o}, 32'd0);
    chk("midrst_op_a", bus.op_a_o, 32'd0);
    chk("midrst_rd", {27'b0, bus.rd_o}, 32'd0);
    bus.out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);

    chk("sb_empty", sb.size(), 32'd0);
    chk("outputs_seen", n_popped, n_pushed);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
